// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: turns a stream of PS/2 Set-2 scancode bytes into single key
// events {brk, ext, code}. An optional filter drops typematic repeat makes.
// Events are buffered in a show-ahead FIFO that drives an AXI-Stream master.
module kbd_event_fifo #(
  parameter int AXIS_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int FILTER_REPEAT   = 1
) (
  input  logic                         axis_aclk_i,
  input  logic                         axis_areset_i,
  input  logic                         ps2_code_new_i,
  input  logic [7:0]                   ps2_code_i,
  input  logic                         m_axis_tready_i,
  output logic                         m_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
  output logic                         overflow_o,
  input  logic                         clear_overflow_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

  state_t          r_state;
  logic            w_is_e0;
  logic            w_is_f0;
  logic            w_is_err;
  logic            w_ext;
  logic            w_brk;
  logic            w_emit;
  logic            w_suppress;

  logic            r_vld_p1;
  logic [9:0]      r_evt_p1;

  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   w_level;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  assign w_is_e0  = (ps2_code_i == 8'hE0);
  assign w_is_f0  = (ps2_code_i == 8'hF0);
  assign w_is_err = (ps2_code_i == 8'h00) || (ps2_code_i == 8'hFF);
  assign w_ext    = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_brk    = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
  assign w_emit   = ps2_code_new_i && !w_is_e0 && !w_is_f0 && !w_is_err;

  // Prefix tracker: E0 restarts the sequence, F0 adds break, anything else ends it.
  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      r_state <= ST_IDLE;
    end else if (ps2_code_new_i) begin
      if (w_is_e0) begin
        r_state <= ST_EXT;
      end else if (w_is_f0) begin
        case (r_state)
          ST_IDLE: r_state <= ST_BRK;
          ST_EXT:  r_state <= ST_EXT_BRK;
          default: r_state <= r_state;
        endcase
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  generate
    if (FILTER_REPEAT != 0) begin : g_filt
      logic       r_last_vld;
      logic [8:0] r_last_key;
      logic       w_match;

      assign w_match    = r_last_vld && (r_last_key == {w_ext, ps2_code_i});
      assign w_suppress = w_emit && !w_brk && w_match;

      // Remembers whether the last accepted make is still held down.
      always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
        if (axis_areset_i) begin
          r_last_vld <= 1'b0;
        end else if (w_emit) begin
          if (!w_brk && !w_match) begin
            r_last_vld <= 1'b1;
          end else if (w_brk && w_match) begin
            r_last_vld <= 1'b0;
          end
        end
      end

      // Key identity of the last accepted make; only meaningful while r_last_vld.
      always_ff @(posedge axis_aclk_i) begin
        if (w_emit && !w_brk && !w_match) begin
          r_last_key <= {w_ext, ps2_code_i};
        end
      end
    end else begin : g_nofilt
      assign w_suppress = 1'b0;
    end
  endgenerate

  // ---- stage p1: decoded event waiting one cycle for FIFO insertion ----
  // Pending-event valid flag.
  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_emit && !w_suppress;
    end
  end

  // Pending-event payload {brk, ext, code}.
  always_ff @(posedge axis_aclk_i) begin
    if (w_emit) begin
      r_evt_p1 <= {w_brk, w_ext, ps2_code_i};
    end
  end

  // ---- FIFO: pointers one bit wider than the index so full/empty are distinct ----
  assign w_level = r_wptr - r_rptr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == PW'(FIFO_DEPTH));
  assign w_pop   = !w_empty && m_axis_tready_i;
  assign w_push  = r_vld_p1 && (!w_full || w_pop);
  assign w_drop  = r_vld_p1 && w_full && !w_pop;

  // Read/write pointer advance.
  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Event storage write.
  always_ff @(posedge axis_aclk_i) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= r_evt_p1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge axis_aclk_i or posedge axis_areset_i) begin
    if (axis_areset_i) begin
      overflow_o <= 1'b0;
    end else if (w_drop) begin
      overflow_o <= 1'b1;
    end else if (clear_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end

  // Show-ahead head; forced to zero when nothing is queued.
  always_comb begin
    m_axis_tdata_o = '0;
    if (!w_empty) begin
      m_axis_tdata_o[9:0] = r_mem[r_rptr[AW-1:0]];
    end
  end

  assign m_axis_tvalid_o = !w_empty;
  assign fifo_level_o    = w_level;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Testbench for kbd_event_fifo: directed scenarios plus randomized byte
// streams, checked by a scoreboard fed from a queue-based reference model.
module tb_kbd_event_fifo;
  localparam int D  = 16;
  localparam int W  = 16;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          nw  = 1'b0;
  logic [7:0]    code = 8'h00;
  logic          rdy = 1'b0;
  logic          clr = 1'b0;

  logic          tvalid;
  logic [W-1:0]  tdata;
  logic [LW-1:0] level;
  logic          ovf;
  logic          nf_tvalid;
  logic [W-1:0]  nf_tdata;
  logic [LW-1:0] nf_level;
  logic          nf_ovf;

  always #5 clk = ~clk;

  kbd_event_fifo #(.AXIS_DATA_WIDTH(W), .FIFO_DEPTH(D), .FILTER_REPEAT(1)) u_dut (
    .axis_aclk_i(clk), .axis_areset_i(rst), .ps2_code_new_i(nw), .ps2_code_i(code),
    .m_axis_tready_i(rdy), .m_axis_tvalid_o(tvalid), .m_axis_tdata_o(tdata),
    .fifo_level_o(level), .overflow_o(ovf), .clear_overflow_i(clr));

  kbd_event_fifo #(.AXIS_DATA_WIDTH(W), .FIFO_DEPTH(D), .FILTER_REPEAT(0)) u_nf (
    .axis_aclk_i(clk), .axis_areset_i(rst), .ps2_code_new_i(nw), .ps2_code_i(code),
    .m_axis_tready_i(rdy), .m_axis_tvalid_o(nf_tvalid), .m_axis_tdata_o(nf_tdata),
    .fifo_level_o(nf_level), .overflow_o(nf_ovf), .clear_overflow_i(clr));

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  bit nf_win = 1'b0;

  // Reference model state: which prefixes have been seen, the key currently
  // held (for repeat filtering), the event decoded last cycle, FIFO contents.
  bit         m_ext, m_brk;
  bit         m_last_v;
  logic [8:0] m_last;
  bit         m_pend_v;
  logic [9:0] m_pend;
  logic [9:0] m_fifo[$];
  bit         m_ovf;
  logic [9:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] nf_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_last_v = 0; m_last = '0;
    m_pend_v = 0; m_pend = '0; m_ovf = 0;
    m_fifo.delete(); exp_q.delete();
  endtask

  // What one clock edge does, given the inputs held during it.
  task automatic model_edge(input bit v, input logic [7:0] c, input bit r, input bit cl);
    int  s;
    bit  pop, drop, keep;
    logic [9:0] ev;
    s = m_fifo.size();
    pop = (s > 0) && r;
    drop = 0;
    if (pop) void'(m_fifo.pop_front());
    if (m_pend_v) begin
      if (s < D || pop) begin
        m_fifo.push_back(m_pend);
        exp_q.push_back(m_pend);
      end else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (cl) m_ovf = 0;
    m_pend_v = 0;
    if (v) begin
      if (c == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (c == 8'hF0) begin
        m_brk = 1;
      end else if (c == 8'h00 || c == 8'hFF) begin
        m_ext = 0; m_brk = 0;
      end else begin
        ev = {m_brk, m_ext, c};
        keep = 1;
        if (!m_brk) begin
          if (m_last_v && m_last == {m_ext, c}) keep = 0;
          else begin m_last_v = 1; m_last = {m_ext, c}; end
        end else if (m_last_v && m_last == {m_ext, c}) begin
          m_last_v = 0;
        end
        m_pend_v = keep;
        m_pend = ev;
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  // Called just after an edge: drive inputs, wait for the next edge, update model.
  task automatic step(input bit v, input logic [7:0] c, input bit r, input bit cl);
    nw = v; code = c; rdy = r; clr = cl;
    @(posedge clk);
    model_edge(v, c, r, cl);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) step(1'b0, 8'h00, r, 1'b0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("level", 32'(level), 32'(m_fifo.size()));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("tvalid", 32'(tvalid), 32'(m_fifo.size() != 0));
      if (tvalid && rdy) begin
        got_q.push_back(tdata);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", tdata);
        end else begin
          chk("tdata", 32'(tdata), 32'(exp_q.pop_front()));
        end
      end
      if (nf_win && nf_tvalid && rdy) nf_q.push_back(nf_tdata);
    end
  end

  initial begin
    int t;
    int k;
    int ph;
    logic [7:0] pool [10];
    pool = '{8'hE0, 8'hF0, 8'h00, 8'hFF, 8'h1C, 8'h75, 8'h1D, 8'hE1, 8'hAA, 8'h12};
    model_reset();
    #2;
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(ovf), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Single make with 2-cycle latency
    got_q.delete();
    step(1, 8'h1C, 1, 0);
    chk("lat_tvalid_k", 32'(tvalid), 0);
    idle(1, 1);
    chk("lat_tvalid_k1", 32'(tvalid), 1);
    chk("lat_tdata", 32'(tdata), 32'h001C);
    idle(3, 1);
    chk("t1_beats", 32'(got_q.size()), 1);
    chk("t1_level", 32'(level), 0);

    // Extended break and plain break
    got_q.delete();
    step(1, 8'hE0, 1, 0); step(1, 8'hF0, 1, 0); step(1, 8'h75, 1, 0);
    step(1, 8'hF0, 1, 0); step(1, 8'h1C, 1, 0);
    idle(4, 1);
    chk("t2_beats", 32'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      chk("t2_extbrk", 32'(got_q[0]), 32'h0375);
      chk("t2_brk", 32'(got_q[1]), 32'h021C);
    end

    // Repeat filter versus unfiltered instance
    got_q.delete(); nf_q.delete(); nf_win = 1;
    step(1, 8'h1C, 1, 0); step(1, 8'h1C, 1, 0); step(1, 8'h1C, 1, 0);
    step(1, 8'hF0, 1, 0); step(1, 8'h1C, 1, 0); step(1, 8'h1C, 1, 0);
    idle(4, 1);
    nf_win = 0;
    chk("t3_beats", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      chk("t3_b0", 32'(got_q[0]), 32'h001C);
      chk("t3_b1", 32'(got_q[1]), 32'h021C);
      chk("t3_b2", 32'(got_q[2]), 32'h001C);
    end
    chk("t3_nf_beats", 32'(nf_q.size()), 5);
    if (nf_q.size() == 5) chk("t3_nf_b3", 32'(nf_q[3]), 32'h021C);

    // Overflow with stalled consumer, then drain and clear
    got_q.delete();
    for (int i = 0; i < D + 2; i++) step(1, 8'(8'h20 + i), 0, 0);
    idle(2, 0);
    chk("t4_level_full", 32'(level), D);
    chk("t4_ovf_set", 32'(ovf), 1);
    idle(D + 2, 1);
    chk("t4_beats", 32'(got_q.size()), D);
    for (int i = 0; i < D; i++)
      if (i < got_q.size()) chk("t4_order", 32'(got_q[i]), 32'(8'h20 + i));
    chk("t4_ovf_held", 32'(ovf), 1);
    step(0, 8'h00, 1, 1);
    chk("t4_ovf_clr", 32'(ovf), 0);

    // Full FIFO with simultaneous push and pop across pointer wrap
    got_q.delete();
    for (int i = 0; i < D; i++) step(1, 8'(8'h40 + i), 0, 0);
    idle(1, 0);
    step(1, 8'h60, 0, 0);
    chk("t5_full", 32'(level), D);
    for (int i = 1; i <= D + 3; i++) begin
      step(1, 8'(8'h60 + i), 1, 0);
      chk("t5_level_stays", 32'(level), D);
      chk("t5_no_ovf", 32'(ovf), 0);
    end
    idle(D + 4, 1);
    chk("t5_beats", 32'(got_q.size()), D + D + 4);
    for (int i = 0; i < D + D + 4; i++)
      if (i < got_q.size())
        chk("t5_order", 32'(got_q[i]), (i < D) ? 32'(8'h40 + i) : 32'(8'h60 + i - D));

    // Reset mid-sequence with events queued
    step(1, 8'h11, 0, 0); step(1, 8'h12, 0, 0); step(1, 8'h13, 0, 0);
    step(1, 8'hE0, 0, 0);
    chk("t6_queued", 32'(level), 3);
    mon_en = 0;
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", 32'(tvalid), 0);
    chk("t6_rst_level", 32'(level), 0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;
    got_q.delete();
    step(1, 8'h75, 1, 0);
    step(1, 8'h00, 1, 0); step(1, 8'hFF, 1, 0);
    idle(4, 1);
    chk("t6_beats", 32'(got_q.size()), 1);
    if (got_q.size() == 1) chk("t6_no_stale_ext", 32'(got_q[0]), 32'h0075);

    // Randomized traffic with phases of heavy back-pressure
    for (int i = 0; i < 3000; i++) begin
      ph = (i / 300) % 2;
      k = $urandom_range(0, 9);
      step(($urandom % 4) != 0, pool[k],
           ph ? (($urandom % 4) == 0) : (($urandom % 4) != 0),
           ($urandom % 40) == 0);
    end

    // Bounded final drain
    t = 0;
    while ((m_fifo.size() != 0 || m_pend_v) && t < 200) begin
      idle(1, 1);
      t++;
    end
    chk("drain_in_time", 32'(t < 200), 1);
    idle(2, 1);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("final_tvalid", 32'(tvalid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
